usb_host_bus_master: RTL and testbench

USB_HOST_BUS_MASTER -- requirements
Module: usb_host_bus_master

---
 rtl/usb_host_bus_master.sv | 175 +++++++++++++++++
 tb/tb_usb_host_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_bus_master.sv
// Byte-wide USB-side bus master: runs SETUP/STROBE/HOLD cycles for single or burst read/write commands.
// Optional feature macro: USB_MASTER_BURST_EN (honour cmd_len; otherwise every command moves one byte).
module usb_host_bus_master #(
  parameter int pADDR_WIDTH = 21,
  parameter int pLEN_WIDTH  = 7,
  parameter int pSETUP      = 1,
  parameter int pSTROBE     = 2,
  parameter int pHOLD       = 1
) (
  input  logic                   usb_clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pLEN_WIDTH-1:0]  cmd_len,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [7:0]             wdata,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  output logic [pADDR_WIDTH-1:0] usb_addr,
  output logic                   usb_cen,
  output logic                   usb_rdn,
  output logic                   usb_wrn,
  output logic [7:0]             usb_dout,
  output logic                   usb_oe,
  input  logic [7:0]             usb_din,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [3:0] LP_SETUP  = 4'(pSETUP - 1);
  localparam logic [3:0] LP_STROBE = 4'(pSTROBE - 1);
  localparam logic [3:0] LP_HOLD   = 4'(pHOLD - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_write;

`ifdef USB_MASTER_BURST_EN
  logic [pLEN_WIDTH-1:0] r_remain;
`else
  logic w_unused_len;
  assign w_unused_len = ^cmd_len;
`endif

  always_ff @(posedge usb_clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      usb_addr    <= '0;
      usb_cen     <= 1'b1;
      usb_rdn     <= 1'b1;
      usb_wrn     <= 1'b1;
      usb_dout    <= '0;
      usb_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef USB_MASTER_BURST_EN
      r_remain    <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_write   <= cmd_write;
            // Address is safe to present early: usb_cen stays high until SETUP.
            usb_addr  <= cmd_addr;
`ifdef USB_MASTER_BURST_EN
            r_remain  <= cmd_len;
`endif
            if (cmd_write) begin
              r_state     <= S_WDATA;
              wdata_ready <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_cnt   <= LP_SETUP;
              usb_cen <= 1'b0;
              usb_oe  <= 1'b0;
            end
          end
        end

        S_WDATA: begin
          if (wdata_valid) begin
            usb_dout    <= wdata;
            wdata_ready <= 1'b0;
            r_state     <= S_SETUP;
            r_cnt       <= LP_SETUP;
            usb_cen     <= 1'b0;
            usb_oe      <= 1'b1;
          end
        end

        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_STROBE;
            r_cnt   <= LP_STROBE;
            usb_wrn <= ~r_write;
            usb_rdn <= r_write;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_HOLD;
            r_cnt   <= LP_HOLD;
            usb_wrn <= 1'b1;
            usb_rdn <= 1'b1;
            // Read data is captured on the edge that releases the strobe.
            if (!r_write) begin
              rd_data  <= usb_din;
              rd_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_HOLD: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
`ifdef USB_MASTER_BURST_EN
          else if (r_remain != '0) begin
            r_remain <= r_remain - 1'b1;
            usb_addr <= usb_addr + 1'b1;
            if (r_write) begin
              r_state     <= S_WDATA;
              wdata_ready <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_cnt   <= LP_SETUP;
            end
          end
`endif
          else begin
            r_state   <= S_IDLE;
            usb_cen   <= 1'b1;
            usb_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_host_bus_master.sv
// Directed bench for usb_host_bus_master; burst-only or single-byte-only steps selected by USB_MASTER_BURST_EN.
module tb_usb_host_bus_master;

  logic        usb_clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [20:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  wdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [20:0] usb_addr;
  logic        usb_cen;
  logic        usb_rdn;
  logic        usb_wrn;
  logic [7:0]  usb_dout;
  logic        usb_oe;
  logic [7:0]  usb_din;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  usb_host_bus_master dut (
    .usb_clk     (usb_clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .usb_addr    (usb_addr),
    .usb_cen     (usb_cen),
    .usb_rdn     (usb_rdn),
    .usb_wrn     (usb_wrn),
    .usb_dout    (usb_dout),
    .usb_oe      (usb_oe),
    .usb_din     (usb_din),
    .busy        (busy),
    .done        (done)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge usb_clk);
    #1;
    chk("strobe_excl", 32'(!usb_rdn && !usb_wrn), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    usb_din     = '0;

    // Reset state
    #12;
    chk("rst_cen", 32'(usb_cen), 32'd1);
    chk("rst_rdn", 32'(usb_rdn), 32'd1);
    chk("rst_wrn", 32'(usb_wrn), 32'd1);
    chk("rst_oe", 32'(usb_oe), 32'd0);
    chk("rst_addr", 32'(usb_addr), 32'd0);
    chk("rst_dout", 32'(usb_dout), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge usb_clk);
    resetn = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single write 0xA5 to 0x00040
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 21'h00040; cmd_len = '0;
    wdata_valid = 1'b1; wdata = 8'hA5;
    tick();
    chk("w_wd_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("w_wd_busy", 32'(busy), 32'd1);
    chk("w_wd_wdata_ready", 32'(wdata_ready), 32'd1);
    chk("w_wd_cen", 32'(usb_cen), 32'd1);
    chk("w_wd_oe", 32'(usb_oe), 32'd0);
    cmd_valid = 1'b0;
    tick();
    chk("w_su_cen", 32'(usb_cen), 32'd0);
    chk("w_su_oe", 32'(usb_oe), 32'd1);
    chk("w_su_addr", 32'(usb_addr), 32'h40);
    chk("w_su_dout", 32'(usb_dout), 32'hA5);
    chk("w_su_wrn", 32'(usb_wrn), 32'd1);
    chk("w_su_wdata_ready", 32'(wdata_ready), 32'd0);
    wdata = 8'hFF;
    tick();
    chk("w_st1_wrn", 32'(usb_wrn), 32'd0);
    chk("w_st1_rdn", 32'(usb_rdn), 32'd1);
    chk("w_st1_dout", 32'(usb_dout), 32'hA5);
    tick();
    chk("w_st2_wrn", 32'(usb_wrn), 32'd0);
    chk("w_st2_done", 32'(done), 32'd0);
    tick();
    chk("w_hd_wrn", 32'(usb_wrn), 32'd1);
    chk("w_hd_cen", 32'(usb_cen), 32'd0);
    chk("w_hd_oe", 32'(usb_oe), 32'd1);
    chk("w_hd_addr", 32'(usb_addr), 32'h40);
    chk("w_hd_dout", 32'(usb_dout), 32'hA5);
    chk("w_hd_done", 32'(done), 32'd0);
    tick();
    chk("w_end_done", 32'(done), 32'd1);
    chk("w_end_cen", 32'(usb_cen), 32'd1);
    chk("w_end_oe", 32'(usb_oe), 32'd0);
    chk("w_end_busy", 32'(busy), 32'd0);
    chk("w_end_cmd_ready", 32'(cmd_ready), 32'd1);
    wdata_valid = 1'b0;
    tick();
    chk("w_post_done", 32'(done), 32'd0);

    // Single read from 0x1FFFFF, 0x3C on the bus only while strobed
    usb_din = 8'h11;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 21'h1FFFFF; cmd_len = '0;
    tick();
    chk("r_su_cen", 32'(usb_cen), 32'd0);
    chk("r_su_oe", 32'(usb_oe), 32'd0);
    chk("r_su_addr", 32'(usb_addr), 32'h1FFFFF);
    chk("r_su_rdn", 32'(usb_rdn), 32'd1);
    chk("r_su_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    usb_din = 8'h3C;
    tick();
    chk("r_st1_rdn", 32'(usb_rdn), 32'd0);
    chk("r_st1_wrn", 32'(usb_wrn), 32'd1);
    chk("r_st1_oe", 32'(usb_oe), 32'd0);
    tick();
    chk("r_st2_rdn", 32'(usb_rdn), 32'd0);
    chk("r_st2_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("r_hd_rdn", 32'(usb_rdn), 32'd1);
    chk("r_hd_rd_valid", 32'(rd_valid), 32'd1);
    chk("r_hd_rd_data", 32'(rd_data), 32'h3C);
    chk("r_hd_oe", 32'(usb_oe), 32'd0);
    chk("r_hd_cen", 32'(usb_cen), 32'd0);
    usb_din = 8'h77;
    tick();
    chk("r_end_rd_valid", 32'(rd_valid), 32'd0);
    chk("r_end_done", 32'(done), 32'd1);
    chk("r_end_rd_data", 32'(rd_data), 32'h3C);
    chk("r_end_cen", 32'(usb_cen), 32'd1);
    tick();
    chk("r_post_done", 32'(done), 32'd0);

`ifdef USB_MASTER_BURST_EN
    // Burst read of 4 bytes across the top of the address space
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 21'h1FFFFE; cmd_len = 7'd3;
    usb_din = 8'h50;
    tick();
    cmd_valid = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
        logic [20:0] ea;
        int ph;
        ph = k % 4;
        ea = 21'h1FFFFE + 21'(k / 4);
        chk("br_addr", 32'(usb_addr), 32'(ea));
        chk("br_cen", 32'(usb_cen), 32'd0);
        chk("br_oe", 32'(usb_oe), 32'd0);
        chk("br_rdn", 32'(usb_rdn), 32'((ph == 1 || ph == 2) ? 0 : 1));
        chk("br_rd_valid", 32'(rd_valid), 32'(ph == 3));
        chk("br_done", 32'(done), 32'd0);
        if (ph == 3) chk("br_rd_data", 32'(rd_data), 32'(8'h50 + 8'(k / 4)));
        if (rd_valid) pulses++;
        usb_din = 8'h50 + 8'(k / 4);
        tick();
      end
      chk("br_pulses", 32'(pulses), 32'd4);
    end
    chk("br_end_done", 32'(done), 32'd1);
    chk("br_end_cen", 32'(usb_cen), 32'd1);
    chk("br_end_busy", 32'(busy), 32'd0);
    tick();
    chk("br_post_done", 32'(done), 32'd0);

    // Burst write of 2 bytes with the second byte withheld for 10 cycles
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 21'h00010; cmd_len = 7'd1;
    wdata_valid = 1'b1; wdata = 8'hB1;
    tick();
    chk("bw_wd0_cen", 32'(usb_cen), 32'd1);
    cmd_valid = 1'b0;
    tick();
    chk("bw_su0_addr", 32'(usb_addr), 32'h10);
    chk("bw_su0_dout", 32'(usb_dout), 32'hB1);
    wdata_valid = 1'b0;
    tick();
    tick();
    chk("bw_st0_wrn", 32'(usb_wrn), 32'd0);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bw_stall_cen", 32'(usb_cen), 32'd0);
      chk("bw_stall_wrn", 32'(usb_wrn), 32'd1);
      chk("bw_stall_rdn", 32'(usb_rdn), 32'd1);
      chk("bw_stall_wdata_ready", 32'(wdata_ready), 32'd1);
      chk("bw_stall_busy", 32'(busy), 32'd1);
      chk("bw_stall_dout", 32'(usb_dout), 32'hB1);
      chk("bw_stall_addr", 32'(usb_addr), 32'h11);
      chk("bw_stall_done", 32'(done), 32'd0);
      tick();
    end
    wdata_valid = 1'b1; wdata = 8'hB2;
    tick();
    chk("bw_su1_addr", 32'(usb_addr), 32'h11);
    chk("bw_su1_dout", 32'(usb_dout), 32'hB2);
    chk("bw_su1_cen", 32'(usb_cen), 32'd0);
    wdata_valid = 1'b0;
    tick();
    chk("bw_st1_wrn", 32'(usb_wrn), 32'd0);
    tick();
    tick();
    chk("bw_hd1_wrn", 32'(usb_wrn), 32'd1);
    chk("bw_hd1_done", 32'(done), 32'd0);
    tick();
    chk("bw_end_done", 32'(done), 32'd1);
    chk("bw_end_cen", 32'(usb_cen), 32'd1);
    tick();
`else
    // Single-byte build: cmd_len must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 21'h00100; cmd_len = 7'd5;
    wdata_valid = 1'b1; wdata = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("nb_su_addr", 32'(usb_addr), 32'h100);
    chk("nb_su_dout", 32'(usb_dout), 32'h5A);
    wdata_valid = 1'b0;
    tick();
    chk("nb_st_wrn", 32'(usb_wrn), 32'd0);
    tick();
    tick();
    chk("nb_hd_done", 32'(done), 32'd0);
    tick();
    chk("nb_end_done", 32'(done), 32'd1);
    chk("nb_end_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("nb_idle_busy", 32'(busy), 32'd0);
      chk("nb_idle_cen", 32'(usb_cen), 32'd1);
      chk("nb_idle_wrn", 32'(usb_wrn), 32'd1);
      chk("nb_idle_done", 32'(done), 32'd0);
      chk("nb_idle_addr", 32'(usb_addr), 32'h100);
    end
`endif

    // Reset asserted during the strobe of a read
    usb_din = 8'h99;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 21'h00123; cmd_len = '0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rr_st_rdn", 32'(usb_rdn), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rr_rdn", 32'(usb_rdn), 32'd1);
    chk("rr_cen", 32'(usb_cen), 32'd1);
    chk("rr_rd_valid", 32'(rd_valid), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_addr", 32'(usb_addr), 32'd0);
    @(negedge usb_clk);
    resetn = 1'b1;
    tick();
    chk("rr_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("rr_post_rd_valid", 32'(rd_valid), 32'd0);
      chk("rr_post_done", 32'(done), 32'd0);
      chk("rr_post_cen", 32'(usb_cen), 32'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
